// File: rtl/tia_pkg.sv
// Shared constants and the LFSR next-state function for the TIA horizontal counter.
// The HC_* values are the counter states reached after 0/4/8/17/19/37/56 steps from zero.
package tia_pkg;

  localparam int HC_WIDTH = 6;

  localparam logic [HC_WIDTH-1:0] HC_SHB  = 6'b000000;  // index 0: line start
  localparam logic [HC_WIDTH-1:0] HC_SHS  = 6'b111100;  // index 4: hsync on
  localparam logic [HC_WIDTH-1:0] HC_RHS  = 6'b110111;  // index 8: hsync off
  localparam logic [HC_WIDTH-1:0] HC_RHB  = 6'b101110;  // index 17: hblank off (no hmove)
  localparam logic [HC_WIDTH-1:0] HC_LRHB = 6'b101011;  // index 19: late hblank off
  localparam logic [HC_WIDTH-1:0] HC_CNT  = 6'b110110;  // index 37: centre
  localparam logic [HC_WIDTH-1:0] HC_END  = 6'b010100;  // index 56: last count

  function automatic logic [HC_WIDTH-1:0] hc_next(input logic [HC_WIDTH-1:0] q);
    return {q[0] ~^ q[1], q[HC_WIDTH-1:1]};
  endfunction

endpackage

// File: rtl/tia_horizontal_counter_if.sv
// Signal bundle between the timing front end (biphase generator, register decoder)
// and the horizontal counter.
// No valid/ready handshake: phi1/phi2 are level enables sampled each clk; rsync and
// hmove are single-clk strobes; shb/hcenter/line_end are single-clk pulses.
interface tia_horizontal_counter_if;
  import tia_pkg::*;

  logic                phi1;
  logic                phi2;
  logic                rsync;
  logic                hmove;
  logic [HC_WIDTH-1:0] hc;
  logic                hblank;
  logic                hsync;
  logic                shb;
  logic                hcenter;
  logic                line_end;

  modport master (
    output phi1, phi2, rsync, hmove,
    input  hc, hblank, hsync, shb, hcenter, line_end
  );

  modport slave (
    input  phi1, phi2, rsync, hmove,
    output hc, hblank, hsync, shb, hcenter, line_end
  );

endinterface

// File: rtl/tia_lfsr6.sv
// Two-phase master/slave 6-bit polynomial counter: phi1 computes the next value into
// the master stage, phi2 commits the master stage into the visible count.
module tia_lfsr6
  import tia_pkg::*;
(
  input  logic                clk,
  input  logic                rl,
  input  logic                phi1,
  input  logic                phi2,
  input  logic                load_zero,
  output logic [HC_WIDTH-1:0] q,
  output logic [HC_WIDTH-1:0] master
);

  // Both phases high at once is illegal and leaves both stages untouched.
  always_ff @(posedge clk or negedge rl) begin
    if (!rl) begin
      q      <= '0;
      master <= '0;
    end else if (phi1 && !phi2) begin
      master <= load_zero ? '0 : hc_next(q);
    end else if (phi2 && !phi1) begin
      q <= master;
    end
  end

endmodule

// File: rtl/tia_horizontal_counter.sv
// TIA horizontal counter: runs the two-phase LFSR and decodes each committed count
// into hblank/hsync levels and the line start, centre and end pulses.
module tia_horizontal_counter
  import tia_pkg::*;
(
  input  logic                     clk,
  input  logic                     rl,
  tia_horizontal_counter_if.slave  bus
);

  logic                p1_edge;
  logic                p2_edge;
  logic                load_zero;
  logic                rsync_pend;
  logic                hmove_lat;
  logic                hblank_q;
  logic                hsync_q;
  logic                shb_q;
  logic                hcenter_q;
  logic                line_end_q;
  logic [HC_WIDTH-1:0] hc_q;
  logic [HC_WIDTH-1:0] master;

  assign p1_edge   = bus.phi1 & ~bus.phi2;
  assign p2_edge   = bus.phi2 & ~bus.phi1;
  // A strobe on the same clk as phi1 is honoured on that very edge.
  assign load_zero = rsync_pend | bus.rsync | (hc_q == HC_END);

  tia_lfsr6 u_lfsr (
    .clk       (clk),
    .rl        (rl),
    .phi1      (bus.phi1),
    .phi2      (bus.phi2),
    .load_zero (load_zero),
    .q         (hc_q),
    .master    (master)
  );

  // Decodes look at master on the commit edge, so they land together with hc.
  always_ff @(posedge clk or negedge rl) begin
    if (!rl) begin
      rsync_pend <= 1'b0;
      hmove_lat  <= 1'b0;
      hblank_q   <= 1'b1;
      hsync_q    <= 1'b0;
      shb_q      <= 1'b0;
      hcenter_q  <= 1'b0;
      line_end_q <= 1'b0;
    end else begin
      shb_q      <= 1'b0;
      hcenter_q  <= 1'b0;
      line_end_q <= 1'b0;

      if (p1_edge)
        rsync_pend <= 1'b0;
      else if (bus.rsync)
        rsync_pend <= 1'b1;

      if (bus.hmove)
        hmove_lat <= 1'b1;
      else if (p2_edge && master == HC_SHB)
        hmove_lat <= 1'b0;

      if (p2_edge) begin
        if (master == HC_SHB) begin
          hblank_q <= 1'b1;
          shb_q    <= 1'b1;
        end
        if (master == HC_SHS)
          hsync_q <= 1'b1;
        if (master == HC_RHS)
          hsync_q <= 1'b0;
        if (master == HC_RHB && !hmove_lat)
          hblank_q <= 1'b0;
        if (master == HC_LRHB)
          hblank_q <= 1'b0;
        if (master == HC_CNT)
          hcenter_q <= 1'b1;
        if (master == HC_END)
          line_end_q <= 1'b1;
      end
    end
  end

  assign bus.hc       = hc_q;
  assign bus.hblank   = hblank_q;
  assign bus.hsync    = hsync_q;
  assign bus.shb      = shb_q;
  assign bus.hcenter  = hcenter_q;
  assign bus.line_end = line_end_q;

endmodule

// File: tb/tb_tia_horizontal_counter.sv
// Directed bench for tia_horizontal_counter: drives the phi1/idle/phi2/idle pattern,
// logs pulse and level-edge times, and checks line timing against hand-derived values.
module tb_tia_horizontal_counter;

  logic clk;
  logic rl;
  tia_horizontal_counter_if bus ();

  tia_horizontal_counter dut (
    .clk (clk),
    .rl  (rl),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int phase    = 0;
  logic glitch = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // event log (times are clk counts)
  int          shb_t[$];
  int          le_t[$];
  int          cn_t[$];
  int          hs_rise[$];
  int          hs_fall[$];
  int          hb_fall[$];
  logic [5:0]  le_hc[$];
  logic [5:0]  cn_hc[$];
  logic        hs_prev = 1'b0;
  logic        hb_prev = 1'b1;
  logic        shb_prev = 1'b0;
  logic        cn_prev = 1'b0;
  logic        le_prev = 1'b0;
  int          wide = 0;

  always @(negedge clk) begin
    if (rl === 1'b1) begin
      if (bus.shb) shb_t.push_back(cyc);
      if (bus.line_end) begin le_t.push_back(cyc); le_hc.push_back(bus.hc); end
      if (bus.hcenter) begin cn_t.push_back(cyc); cn_hc.push_back(bus.hc); end
      if (bus.hsync && !hs_prev) hs_rise.push_back(cyc);
      if (!bus.hsync && hs_prev) hs_fall.push_back(cyc);
      if (!bus.hblank && hb_prev) hb_fall.push_back(cyc);
      if ((bus.shb && shb_prev) || (bus.hcenter && cn_prev) || (bus.line_end && le_prev))
        wide <= wide + 1;
    end
    hs_prev  <= bus.hsync;
    hb_prev  <= bus.hblank;
    shb_prev <= bus.shb;
    cn_prev  <= bus.hcenter;
    le_prev  <= bus.line_end;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [5:0] lfsr_val(input int n);
    logic [5:0] q;
    q = '0;
    for (int i = 0; i < n; i++) q = {q[0] ~^ q[1], q[5:1]};
    return q;
  endfunction

  function automatic int first_after(input int q[$], input int t);
    foreach (q[i]) if (q[i] > t) return q[i];
    return -1;
  endfunction

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic clear_log();
    shb_t.delete(); le_t.delete(); cn_t.delete();
    hs_rise.delete(); hs_fall.delete(); hb_fall.delete();
    le_hc.delete(); cn_hc.delete();
  endtask

  // driver: one clk of the biphase pattern, strobes last exactly this clk
  task automatic step();
    bus.phi1 = (phase == 0);
    bus.phi2 = (phase == 2);
    if (glitch) begin bus.phi1 = 1'b1; bus.phi2 = 1'b1; end
    @(posedge clk); #1;
    phase = (phase + 1) % 4;
    bus.rsync = 1'b0;
    bus.hmove = 1'b0;
    glitch = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until(input int idx);
    logic [5:0] prev;
    logic [5:0] target;
    int n;
    target = lfsr_val(idx);
    n = 0;
    do begin
      prev = bus.hc;
      step();
      n++;
    end while (!(bus.hc === target && prev !== target) && n < 400);
    n_checks++;
    if (bus.hc !== target) begin
      n_fail++;
      $display("FAIL run_until_idx%0d: hc=%b required %b within 400 clk", idx, bus.hc, target);
    end
  endtask

  task automatic test_reset();
    rl = 1'b0;
    bus.phi1 = 1'b0; bus.phi2 = 1'b0; bus.rsync = 1'b0; bus.hmove = 1'b0;
    step(); step();
    n_checks++; if (bus.hc !== 6'd0) begin n_fail++; $display("FAIL por_hc: got %b required 000000", bus.hc); end
    n_checks++; if (bus.hblank !== 1'b1) begin n_fail++; $display("FAIL por_hblank: got %b required 1", bus.hblank); end
    rl = 1'b1;
    run_until(30);
    n_checks++; if (bus.hblank !== 1'b0) begin n_fail++; $display("FAIL idx30_hblank: got %b required 0", bus.hblank); end
    #2; rl = 1'b0; #1;
    n_checks++; if (bus.hc !== 6'd0) begin n_fail++; $display("FAIL rst_hc: got %b required 000000", bus.hc); end
    n_checks++; if (bus.hblank !== 1'b1) begin n_fail++; $display("FAIL rst_hblank: got %b required 1", bus.hblank); end
    n_checks++; if (bus.hsync !== 1'b0) begin n_fail++; $display("FAIL rst_hsync: got %b required 0", bus.hsync); end
    n_checks++;
    if ({bus.shb, bus.hcenter, bus.line_end} !== 3'b000) begin
      n_fail++; $display("FAIL rst_pulses: got %b required 000", {bus.shb, bus.hcenter, bus.line_end});
    end
    step(); step();
    rl = 1'b1;
  endtask

  task automatic test_free_run();
    int s0, s1, s2;
    clear_log();
    run(760);
    n_checks++; if (shb_t.size() < 3) begin n_fail++; $display("FAIL fr_shb_count: got %0d required >=3", shb_t.size()); end
    s0 = qget(shb_t, 0); s1 = qget(shb_t, 1); s2 = qget(shb_t, 2);
    n_checks++; if (s1 - s0 != 228) begin n_fail++; $display("FAIL fr_line0: got %0d required 228", s1 - s0); end
    n_checks++; if (s2 - s1 != 228) begin n_fail++; $display("FAIL fr_line1: got %0d required 228", s2 - s1); end
    n_checks++; if (first_after(le_t, s0) != s1 - 4) begin n_fail++; $display("FAIL fr_line_end: got %0d required %0d", first_after(le_t, s0), s1 - 4); end
    n_checks++; if (first_after(cn_t, s0) != s0 + 148) begin n_fail++; $display("FAIL fr_hcenter: got %0d required %0d", first_after(cn_t, s0), s0 + 148); end
    n_checks++; if (first_after(hs_rise, s0) != s0 + 16) begin n_fail++; $display("FAIL fr_hsync_rise: got %0d required %0d", first_after(hs_rise, s0), s0 + 16); end
    n_checks++; if (first_after(hs_fall, s0) != s0 + 32) begin n_fail++; $display("FAIL fr_hsync_fall: got %0d required %0d", first_after(hs_fall, s0), s0 + 32); end
    n_checks++; if (first_after(hb_fall, s0) != s0 + 68) begin n_fail++; $display("FAIL fr_hblank_fall: got %0d required %0d", first_after(hb_fall, s0), s0 + 68); end
    n_checks++; if (le_hc.size() == 0 || le_hc[0] !== 6'b010100) begin n_fail++; $display("FAIL fr_hc_at_end: got %0d entries, required hc 010100", le_hc.size()); end
    n_checks++; if (cn_hc.size() == 0 || cn_hc[0] !== lfsr_val(37)) begin n_fail++; $display("FAIL fr_hc_at_centre: got %0d entries, required hc %b", cn_hc.size(), lfsr_val(37)); end
  endtask

  task automatic test_hmove();
    int s0, s1;
    clear_log();
    run_until(0);
    run_until(10);
    bus.hmove = 1'b1;
    step();
    run(500);
    s0 = qget(shb_t, 0); s1 = qget(shb_t, 1);
    n_checks++; if (first_after(hb_fall, s0) - s0 != 76) begin n_fail++; $display("FAIL hmove_hblank: got %0d required 76", first_after(hb_fall, s0) - s0); end
    n_checks++; if (first_after(hb_fall, s1) - s1 != 68) begin n_fail++; $display("FAIL hmove_next_line: got %0d required 68", first_after(hb_fall, s1) - s1); end
  endtask

  task automatic test_rsync();
    int n;
    run_until(30);
    clear_log();
    bus.rsync = 1'b1;
    step();
    n = 0;
    while (bus.hc === lfsr_val(30) && n < 8) begin step(); n++; end
    n_checks++; if (bus.hc !== 6'd0) begin n_fail++; $display("FAIL rsync_next_idx: got %b required 000000", bus.hc); end
    n_checks++; if (bus.shb !== 1'b1) begin n_fail++; $display("FAIL rsync_shb: got %b required 1", bus.shb); end
    run(240);
    n_checks++; if (shb_t.size() != 2) begin n_fail++; $display("FAIL rsync_shb_count: got %0d required 2", shb_t.size()); end
    n_checks++; if (qget(shb_t, 1) - qget(shb_t, 0) != 228) begin n_fail++; $display("FAIL rsync_line: got %0d required 228", qget(shb_t, 1) - qget(shb_t, 0)); end
  endtask

  task automatic test_rsync_at_end();
    run_until(56);
    clear_log();
    bus.rsync = 1'b1;
    step();
    run(240);
    n_checks++; if (shb_t.size() != 2) begin n_fail++; $display("FAIL end_rsync_shb_count: got %0d required 2", shb_t.size()); end
    n_checks++; if (qget(shb_t, 0) - qget(le_t, 0) != 4) begin n_fail++; $display("FAIL end_rsync_wrap: got %0d required 4", qget(shb_t, 0) - qget(le_t, 0)); end
    n_checks++; if (qget(shb_t, 1) - qget(shb_t, 0) != 228) begin n_fail++; $display("FAIL end_rsync_line: got %0d required 228", qget(shb_t, 1) - qget(shb_t, 0)); end
  endtask

  task automatic test_glitch();
    clear_log();
    run_until(0);
    run_until(12);
    glitch = 1'b1;
    step();
    n_checks++; if (bus.hc !== lfsr_val(12)) begin n_fail++; $display("FAIL glitch_hold: got %b required %b", bus.hc, lfsr_val(12)); end
    run(500);
    n_checks++; if (qget(shb_t, 1) - qget(shb_t, 0) != 228) begin n_fail++; $display("FAIL glitch_line: got %0d required 228", qget(shb_t, 1) - qget(shb_t, 0)); end
    n_checks++; if (qget(shb_t, 2) - qget(shb_t, 1) != 228) begin n_fail++; $display("FAIL glitch_next_line: got %0d required 228", qget(shb_t, 2) - qget(shb_t, 1)); end
  endtask

  task automatic test_pulse_width();
    n_checks++; if (wide != 0) begin n_fail++; $display("FAIL pulse_width: got %0d wide pulses required 0", wide); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_hmove();
    test_rsync();
    test_rsync_at_end();
    test_glitch();
    test_pulse_width();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tia_horizontal_counter.md
# tia_horizontal_counter

Downstream consumer of the TIA biphase clock generator. It runs the TIA 6-bit polynomial (LFSR) horizontal counter: one count per phi1/phi2 pair, 57 counts per scanline (228 colour clocks). It also decodes the count into the horizontal timing signals (hblank, hsync, centre, line start/end) used by the playfield, object and vertical stages. RSYNC and HMOVE strobes from the register-write decoder modify line timing.

## Interface
Parameters:
- none; all constants live in the shared package.

Ports:
- clk  in  1  colour clock; the same clock that drives the biphase generator.
- rl  in  1  asynchronous, active-low reset.
- phi1  in  1  biphase phase 1, sampled as a synchronous enable on clk rising edge.
- phi2  in  1  biphase phase 2, sampled as a synchronous enable on clk rising edge.
- rsync  in  1  one-clk strobe from the RSYNC register write.
- hmove  in  1  one-clk strobe from the HMOVE register write.
- hc  out  6  committed LFSR count value.
- hblank  out  1  horizontal blank level.
- hsync  out  1  horizontal sync level.
- shb  out  1  one-clk pulse marking the commit of index 0 (line start).
- hcenter  out  1  one-clk pulse marking the commit of index 37.
- line_end  out  1  one-clk pulse marking the commit of index 56.

## Operation
- Clocking and reset:
  - One clock, clk. Reset is asynchronous and active-low on rl.
  - While rl is low: hc=0, master=0, hblank=1, hsync=0, shb/hcenter/line_end=0, hmove latch=0, rsync pending=0.
- Two-phase shift emulation:
  - phi1-only edge: master <= next(hc), or master <= 000000 if rsync is pending or hc is the index-56 value. rsync pending is then cleared.
  - phi2-only edge: hc <= master ("commit"). All decodes are evaluated on the newly committed value.
  - next(q) = {q[0] ~^ q[1], q[5:1]}. Index n is the value reached after n steps from 000000.
- Edge cases:
  - Both phi1 and phi2 high: illegal. No update to master or hc.
  - Neither high: hold.
  - A phi2 edge with no intervening phi1: recommits master, so hc is unchanged.
- Decodes, applied at commit of index:
  - 0: hblank <= 1; shb pulse; hmove latch cleared.
  - 4: hsync <= 1.
  - 8: hsync <= 0.
  - 17: hblank <= 0 if hmove latch = 0.
  - 19: hblank <= 0.
  - 37: hcenter pulse.
  - 56: line_end pulse.
- rsync: sets the pending flag; it takes effect at the next phi1 edge. rsync arriving on the same clk as a phi1 edge applies on that edge.
- hmove: sets the latch on any clk. If hmove arrives on the same cycle as the index-0 commit, set wins over clear.

## Timing
- With the standard biphase pattern (phi1, idle, phi2, idle), there is one commit every 4 clk.
- Free-run line is 57 commits = 228 clk, shb to shb.
- Pulses are registered: high for exactly the one clk following the commit edge, never wider.
- Latency from phi2 edge to hc, hblank and hsync: same edge (registered outputs update together).
- hsync is high 16 clk per line. hblank is high 68 clk, or 76 clk when the hmove latch is set before the index-17 commit.
- rsync causes the next commit to be index 0. The line restarts and exactly one shb pulse is produced.
- Reset released mid-pattern: counting resumes from index 0 at the first phi1/phi2 pair.

## Structure
- Package tia_pkg holds:
  - HC_WIDTH=6
  - the next-state function
  - LFSR-value constants HC_SHB, HC_SHS, HC_RHS, HC_RHB, HC_LRHB, HC_CNT, HC_END for indices 0/4/8/17/19/37/56, precomputed from next()
- Sub-module tia_lfsr6 holds the master/slave two-phase LFSR, with its phi1/phi2 enables and a load-zero input.
- Decode logic, latches and pulse registers stay in the top module.

## Test plan
- Reset: assert rl low mid-line (hc at index 30) -> immediately hc=0, hblank=1, hsync=0, all pulses 0.
- Free run after reset: shb pulses spaced 228 clk; line_end 4 clk before each shb; hcenter 148 clk after shb; hsync high from shb+16 to shb+32 clk.
- hmove strobe at index 10 -> hblank falls 76 clk after shb; the following line without hmove falls at 68 clk.
- rsync at index 30 -> next commit is index 0 with one shb pulse; the following line measures 228 clk.
- rsync on the cycle hc is index 56 -> single wrap to 0, exactly one shb, no skipped or duplicated line.
- phi1 and phi2 both high for one clk at index 12 -> hc stays at index 12; line length grows by 0 commits, and subsequent spacing is unaffected.
